// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (used by RX and TX),
// legal oversampling ratios, parity-type encodings and a parity helper.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam logic [5:0] PRESC_8  = 6'd8;
    localparam logic [5:0] PRESC_16 = 6'd16;
    localparam logic [5:0] PRESC_32 = 6'd32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Expected parity bit from the XOR-reduction of the data word.
    function automatic logic par_expected(input logic par_typ,
                                          input logic data_xor);
        return data_xor ^ (par_typ == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter with three-tap mid-bit capture and 2-of-3 vote.
// Ports: clk_i/rst_i, rx_i (synchronised line), presc_i (captured ratio),
//        start_i (start detected), active_i (FSM not idle), bit_val_o, bit_end_o.
`timescale 1ns/1ps
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    input  logic [5:0] presc_i,
    input  logic       start_i,
    input  logic       active_i,
    output logic       bit_val_o,
    output logic       bit_end_o
);

    logic [5:0] edge_cnt_q, edge_cnt_d;
    logic [2:0] tap_q, tap_d;
    logic [5:0] half;
    logic       last_edge;

    assign half      = {1'b0, presc_i[5:1]};
    assign last_edge = (edge_cnt_q == presc_i - 6'd1);

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        tap_d      = tap_q;
        // The start-detection cycle itself is edge 0, so counting resumes at 1.
        if (start_i) begin
            edge_cnt_d = 6'd1;
        end else if (active_i) begin
            edge_cnt_d = last_edge ? 6'd0 : edge_cnt_q + 6'd1;
        end else begin
            edge_cnt_d = 6'd0;
        end
        if (active_i) begin
            if (edge_cnt_q == half - 6'd1) tap_d[0] = rx_i;
            if (edge_cnt_q == half)        tap_d[1] = rx_i;
            if (edge_cnt_q == half + 6'd1) tap_d[2] = rx_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            edge_cnt_q <= 6'd0;
            tap_q      <= 3'b111;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            tap_q      <= tap_d;
        end
    end

    assign bit_end_o = active_i && last_edge;
    assign bit_val_o = (tap_q[0] & tap_q[1]) |
                       (tap_q[0] & tap_q[2]) |
                       (tap_q[1] & tap_q[2]);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchroniser, frame FSM, LSB-first deserialiser, parity/stop checks.
// Ports: CLK, RST (sync, active high), RX_IN, PAR_EN, PAR_TYP, PRESCALE in;
//        P_DATA, DATA_VALID, PAR_ERR, STP_ERR out (all registered).
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            PRESCALE,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    logic sync1_q, rx_s_q;

    uart_state_e state_q, state_d;
    logic [5:0]  presc_q, presc_d;
    logic        par_en_q, par_en_d;
    logic        par_typ_q, par_typ_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic        par_mis_q, par_mis_d;
    logic        stop_q, stop_d;
    logic        done_q, done_d;

    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic        valid_q, valid_d;
    logic        par_err_q, par_err_d;
    logic        stp_err_q, stp_err_d;

    logic start_det;
    logic bit_val;
    logic bit_end;

    uart_rx_sampler u_sampler (
        .clk_i     (CLK),
        .rst_i     (RST),
        .rx_i      (rx_s_q),
        .presc_i   (presc_q),
        .start_i   (start_det),
        .active_i  (state_q != IDLE),
        .bit_val_o (bit_val),
        .bit_end_o (bit_end)
    );

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        bit_cnt_d = bit_cnt_q;
        word_d    = word_q;
        par_mis_d = par_mis_q;
        stop_d    = stop_q;
        done_d    = 1'b0;
        p_data_d  = p_data_q;
        valid_d   = 1'b0;
        par_err_d = 1'b0;
        stp_err_d = 1'b0;
        start_det = 1'b0;

        // Frame verdict is issued one cycle after the stop bit closes, so
        // it can overlap detection of a back-to-back start bit.
        if (done_q) begin
            stp_err_d = ~stop_q;
            par_err_d = par_mis_q;
            if (stop_q && !par_mis_q) begin
                p_data_d = word_q;
                valid_d  = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    start_det = 1'b1;
                    state_d   = START;
                    presc_d   = PRESCALE;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    par_mis_d = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    if (bit_val) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            DATA: begin
                if (bit_end) begin
                    word_d[bit_cnt_q] = bit_val;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    par_mis_d = bit_val != par_expected(par_typ_q, ^word_q);
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    stop_d  = bit_val;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            presc_q   <= PRESC_8;
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
            bit_cnt_q <= '0;
            word_q    <= '0;
            par_mis_q <= 1'b0;
            stop_q    <= 1'b1;
            done_q    <= 1'b0;
            p_data_q  <= '0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
        end else begin
            sync1_q   <= RX_IN;
            rx_s_q    <= sync1_q;
            state_q   <= state_d;
            presc_q   <= presc_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            bit_cnt_q <= bit_cnt_d;
            word_q    <= word_d;
            par_mis_q <= par_mis_d;
            stop_q    <= stop_d;
            done_q    <= done_d;
            p_data_q  <= p_data_d;
            valid_q   <= valid_d;
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign DATA_VALID = valid_q;
    assign PAR_ERR    = par_err_q;
    assign STP_ERR    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected frame verdicts,
// a negedge monitor pops and compares whenever any output flag pulses.
`timescale 1ns/1ps
module tb_uart_rx;
    import uart_pkg::*;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] PRESCALE;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_ERR;
    logic       STP_ERR;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .PRESCALE   (PRESCALE),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] data;
        logic [2:0] flags;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   passes = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Monitor: every flag pulse must match the oldest outstanding frame.
    always @(negedge CLK) begin
        if (!RST && (DATA_VALID || PAR_ERR || STP_ERR)) begin
            if (sb.size() == 0) begin
                chk("unexpected_flags", {DATA_VALID, PAR_ERR, STP_ERR}, 3'b000);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("flags", {DATA_VALID, PAR_ERR, STP_ERR}, e.flags);
                chk("p_data", P_DATA, e.data);
                chk("latency", cyc, e.due);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // flags = {valid, par_err, stp_err}; pexp = P_DATA expected at the pulse.
    task automatic send_frame(input logic [7:0] d, input int p,
                              input logic pe, input logic pt,
                              input logic pbit, input logic sbit,
                              input logic jit, input logic [2:0] flags,
                              input logic [7:0] pexp);
        exp_t e;
        logic [10:0] bv;
        int nb, len;
        PRESCALE = p[5:0];
        PAR_EN   = pe;
        PAR_TYP  = pt;
        nb = 10 + int'(pe);
        e.data  = pexp;
        e.flags = flags;
        e.due   = cyc + 1 + nb * p + 2;
        sb.push_back(e);
        bv = '1;
        bv[0] = 1'b0;
        for (int j = 0; j < 8; j++) bv[j+1] = d[j];
        if (pe) begin
            bv[9]  = pbit;
            bv[10] = sbit;
        end else begin
            bv[9] = sbit;
        end
        for (int i = 0; i < nb; i++) begin
            RX_IN = bv[i];
            len = p + (jit ? ((i % 2 == 0) ? 2 : -2) : 0);
            repeat (len) @(posedge CLK);
            #1;
        end
        RX_IN = 1'b1;
    endtask

    initial begin
        RST      = 1'b1;
        RX_IN    = 1'b1;
        PRESCALE = PRESC_8;
        PAR_EN   = 1'b0;
        PAR_TYP  = PAR_EVEN;
        idle(3);
        @(negedge CLK);
        chk("rst_p_data", P_DATA, 8'h00);
        chk("rst_valid", DATA_VALID, 1'b0);
        chk("rst_par_err", PAR_ERR, 1'b0);
        chk("rst_stp_err", STP_ERR, 1'b0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        idle(5);

        send_frame(8'hA5, 8, 0, PAR_EVEN, 0, 1, 0, 3'b100, 8'hA5);
        idle(10);
        send_frame(8'h3C, 16, 1, PAR_EVEN, 0, 1, 0, 3'b100, 8'h3C);
        idle(10);
        send_frame(8'h3C, 16, 1, PAR_EVEN, 1, 1, 0, 3'b010, 8'h3C);
        idle(10);
        send_frame(8'h01, 32, 1, PAR_ODD, 0, 0, 0, 3'b001, 8'h3C);
        idle(10);

        PRESCALE = PRESC_8;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        idle(2);
        RX_IN = 1'b1;
        idle(20);
        send_frame(8'h5A, 8, 0, PAR_EVEN, 0, 1, 0, 3'b100, 8'h5A);
        idle(10);

        send_frame(8'h11, 8, 0, PAR_EVEN, 0, 1, 0, 3'b100, 8'h11);
        send_frame(8'h22, 8, 0, PAR_EVEN, 0, 1, 0, 3'b100, 8'h22);
        send_frame(8'h33, 8, 0, PAR_EVEN, 0, 1, 0, 3'b100, 8'h33);
        idle(10);
        send_frame(8'h11, 8, 0, PAR_EVEN, 0, 1, 1, 3'b100, 8'h11);
        send_frame(8'h22, 8, 0, PAR_EVEN, 0, 1, 1, 3'b100, 8'h22);
        send_frame(8'h33, 8, 0, PAR_EVEN, 0, 1, 1, 3'b100, 8'h33);
        idle(10);

        // Frame 0xFF aborted by reset during its data bits.
        PRESCALE = PRESC_8;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        idle(8);
        RX_IN = 1'b1;
        idle(24);
        RST = 1'b1;
        idle(2);
        RST = 1'b0;
        @(negedge CLK);
        chk("mid_rst_p_data", P_DATA, 8'h00);
        chk("mid_rst_valid", DATA_VALID, 1'b0);
        chk("mid_rst_par_err", PAR_ERR, 1'b0);
        chk("mid_rst_stp_err", STP_ERR, 1'b0);
        chk("mid_rst_state", dut.state_q, IDLE);
        idle(20);
        send_frame(8'h81, 8, 0, PAR_EVEN, 0, 1, 0, 3'b100, 8'h81);

        for (int k = 0; k < 2000 && sb.size() != 0; k++) @(posedge CLK);
        idle(20);
        chk("drain", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
